echo_request_beat_rx: RTL and testbench
=======================================

// Module: echo_request_beat_rx
// PURPOSE
// Receive side of the Echo portal word link: accepts a 32-bit beat stream (header + payload words)
// and reassembles each frame into an EchoRequest_data message delivered on pipe.enq.
// Sits ahead of EchoRequestInput. It is the inverse of the beat serializer that flattens pipe.enq messages.
// Frames with an unknown tag or a bad length are discarded whole and counted.
// PARAMETERS
// TAG_SAY    1   tag value of the say method
// SAY_LEN    2   payload words required for TAG_SAY (meth, v)
// ERR_W      8   width of saturating error counter
// PORTS
// CLK            in   1      clock, all state on rising edge
// nRST           in   1      reset, asynchronous assert, active-low
// beat__ENA      in   1      beat offered; only asserted while beat__RDY=1
// beat$v         in   32     beat word
// beat__RDY      out  1      beat can be accepted this cycle
// pipe.enq__ENA  out  1      assembled message valid
// pipe.enq$v     out  96     EchoRequest_data: [95:64]=say.v, [63:32]=say.meth, [31:0]=tag
// pipe.enq__RDY  in   1      downstream accepts; transfer when ENA&&RDY
// err_count      out  ERR_W  frames discarded, saturates at all-ones
// msg_count      out  16     messages delivered, wraps
// BEHAVIOUR
// - Reset: beat__RDY=0 while nRST=0, then 1; pipe.enq__ENA=0; pipe.enq$v=0; counters=0; FSM=HDR.
// - Beat transfer = beat__ENA && beat__RDY; message transfer = pipe.enq__ENA && pipe.enq__RDY.
// - Header word: [15:0]=tag, [31:16]=len (payload word count).
// - FSM (one beat per transition):
//   HDR : len==0 -> HDR (tag==TAG_SAY with len 0 is an error; count it).
//         tag==TAG_SAY && len==SAY_LEN -> METH. Any other tag or len>0 -> DISCARD, remaining=len.
//   METH: capture meth -> V.
//   V   : capture v, load slot with {v, meth, 16'b0, tag} -> HDR.
//   DISCARD: decrement remaining; remaining==1 -> HDR; err_count++ on entry (sat).
// - Output slot (one entry): pipe.enq__ENA = slot_valid. Slot holds value stable until transfer.
// - beat__RDY = 1 except in state V while slot_valid && !pipe.enq__RDY (stall only the last beat).
// - Same-cycle drain+load allowed: V beat accepted while slot drains. Throughput is 1 message per 3 beats.
// - Latency: last beat accepted at cycle t -> pipe.enq__ENA=1 at t+1.
// - msg_count++ on each message transfer; no combinational path beat$v -> pipe.enq$v.
// - Unknown tag with len=0: err_count++, stay HDR.
// - Reset mid-frame: partial frame lost, slot cleared, no message emitted.
// STRUCTURE
// - connect_pkg: EchoRequest_data + union/say typedefs, TAG_SAY, SAY_LEN, header field offsets.
// - Sub-module echo_enq_slot: one-entry ENA/RDY holding register (load, drain, simultaneous).
// - Top: header decode, FSM, remaining counter, meth capture, counters.
// TESTING
// 1 Reset then beats 0x0002_0001, 0x0000_0005, 0x0000_00AA, RDY=1 -> enq$v={32'hAA,32'h5,32'h1} at t+1, msg_count=1.
// 2 Back-to-back 4 say frames, RDY=1 -> beat__RDY never low, 4 messages, 1 per 3 cycles, in order.
// 3 pipe.enq__RDY=0 for 10 cycles over 2 frames -> 2nd frame stalls on its v beat; enq$v stable; both delivered on release.
// 4 Header 0x0003_0007 + 3 junk words then valid say -> err_count=1, only the say delivered.
// 5 Header 0x0001_0001 (bad len) then 0x0000_0000 -> err_count=1; 256 bad frames -> err_count=255 (saturated).
// 6 nRST low after METH beat -> enq__ENA=0 immediately; next full frame decodes correctly, counters=0 before it.

Source files
------------

// File: rtl/connect_pkg.sv
// ============================================================================
// Module : connect_pkg
// Brief  : Echo request message types, header field layout and rx FSM states.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package connect_pkg;

  localparam int unsigned HDR_TAG_LSB = 0;
  localparam int unsigned HDR_TAG_W   = 16;
  localparam int unsigned HDR_LEN_LSB = 16;
  localparam int unsigned HDR_LEN_W   = 16;

  localparam logic [15:0] DEF_TAG_SAY = 16'd1;
  localparam logic [15:0] DEF_SAY_LEN = 16'd2;

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] meth;
  } echo_say_t;

  typedef union packed {
    echo_say_t say;
  } echo_request_u;

  typedef struct packed {
    echo_request_u data;
    logic [31:0]   tag;
  } echo_request_data_t;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_METH    = 2'd1,
    ST_V       = 2'd2,
    ST_DISCARD = 2'd3
  } rx_state_e;

  function automatic logic [HDR_TAG_W-1:0] hdr_tag(input logic [31:0] word);
    return word[HDR_TAG_LSB +: HDR_TAG_W];
  endfunction

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [31:0] word);
    return word[HDR_LEN_LSB +: HDR_LEN_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/echo_enq_slot.sv
// ============================================================================
// Module : echo_enq_slot
// Brief  : One-entry ENA/RDY holding register; load and drain may coincide.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module echo_enq_slot #(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_deq_rdy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Caller only loads when the slot is empty or draining this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && i_deq_rdy) begin
      valid_d = 1'b0;
    end
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/echo_request_beat_rx.sv
// ============================================================================
// Module : echo_request_beat_rx
// Brief  : Reassembles 32-bit header+payload beats into EchoRequest messages.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module echo_request_beat_rx
  import connect_pkg::*;
#(
  parameter logic [15:0] TAG_SAY = DEF_TAG_SAY,
  parameter logic [15:0] SAY_LEN = DEF_SAY_LEN,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             beat__ENA,
  input  logic [31:0]      beat_v,
  output logic             beat__RDY,
  output logic             pipe_enq__ENA,
  output logic [95:0]      pipe_enq_v,
  input  logic             pipe_enq__RDY,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      msg_count
);

  rx_state_e          state_d, state_q;
  logic [15:0]        remaining_d, remaining_q;
  logic [15:0]        tag_d, tag_q;
  logic [31:0]        meth_d, meth_q;
  logic [ERR_W-1:0]   err_d, err_q;
  logic [15:0]        msg_d, msg_q;
  logic               live_q;

  logic               w_slot_valid;
  logic [95:0]        w_slot_data;
  logic               w_slot_load;
  echo_request_data_t w_load_data;
  logic               w_stall;
  logic               w_beat_fire;
  logic               w_msg_fire;
  logic               w_err_inc;
  logic [15:0]        w_tag;
  logic [15:0]        w_len;

  assign w_tag = hdr_tag(beat_v);
  assign w_len = hdr_len(beat_v);

  // Only the closing v beat needs the slot, so only it waits for downstream.
  assign w_stall     = (state_q == ST_V) && w_slot_valid && !pipe_enq__RDY;
  assign beat__RDY   = live_q && !w_stall;
  assign w_beat_fire = beat__ENA && beat__RDY;
  assign w_msg_fire  = w_slot_valid && pipe_enq__RDY;

  always_comb begin
    state_d                  = state_q;
    remaining_d              = remaining_q;
    tag_d                    = tag_q;
    meth_d                   = meth_q;
    w_err_inc                = 1'b0;
    w_slot_load              = 1'b0;
    w_load_data.data.say.v    = beat_v;
    w_load_data.data.say.meth = meth_q;
    w_load_data.tag          = {16'b0, tag_q};

    case (state_q)
      ST_HDR: begin
        if (w_beat_fire) begin
          if (w_len == 16'd0) begin
            w_err_inc = 1'b1;
          end else if ((w_tag == TAG_SAY) && (w_len == SAY_LEN)) begin
            tag_d   = w_tag;
            state_d = ST_METH;
          end else begin
            remaining_d = w_len;
            w_err_inc   = 1'b1;
            state_d     = ST_DISCARD;
          end
        end
      end
      ST_METH: begin
        if (w_beat_fire) begin
          meth_d  = beat_v;
          state_d = ST_V;
        end
      end
      ST_V: begin
        if (w_beat_fire) begin
          w_slot_load = 1'b1;
          state_d     = ST_HDR;
        end
      end
      ST_DISCARD: begin
        if (w_beat_fire) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = ST_HDR;
          end
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (w_err_inc && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
    msg_d = msg_q;
    if (w_msg_fire) begin
      msg_d = msg_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_HDR;
      remaining_q <= 16'd0;
      tag_q       <= 16'd0;
      meth_q      <= 32'd0;
      err_q       <= '0;
      msg_q       <= 16'd0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tag_q       <= tag_d;
      meth_q      <= meth_d;
      err_q       <= err_d;
      msg_q       <= msg_d;
      live_q      <= 1'b1;
    end
  end

  echo_enq_slot #(
    .WIDTH (96)
  ) u_slot (
    .clk         (CLK),
    .rst_n       (nRST),
    .i_load      (w_slot_load),
    .i_load_data (w_load_data),
    .i_deq_rdy   (pipe_enq__RDY),
    .o_valid     (w_slot_valid),
    .o_data      (w_slot_data)
  );

  assign pipe_enq__ENA = w_slot_valid;
  assign pipe_enq_v    = w_slot_data;
  assign err_count     = err_q;
  assign msg_count     = msg_q;

endmodule

`default_nettype wire

// File: tb/tb_echo_request_beat_rx.sv
// ============================================================================
// Module : tb_echo_request_beat_rx
// Brief  : Directed scoreboard bench for echo_request_beat_rx.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_echo_request_beat_rx;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        beat__ENA;
  logic [31:0] beat_v;
  logic        beat__RDY;
  logic        pipe_enq__ENA;
  logic [95:0] pipe_enq_v;
  logic        pipe_enq__RDY;
  logic [7:0]  err_count;
  logic [15:0] msg_count;

  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          stall_waits = 0;
  logic [95:0] sb[$];
  int          xfer_cyc[$];
  logic        prev_stall = 1'b0;
  logic [95:0] prev_data = '0;

  echo_request_beat_rx #(
    .TAG_SAY (16'd1),
    .SAY_LEN (16'd2),
    .ERR_W   (8)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .beat__ENA     (beat__ENA),
    .beat_v        (beat_v),
    .beat__RDY     (beat__RDY),
    .pipe_enq__ENA (pipe_enq__ENA),
    .pipe_enq_v    (pipe_enq_v),
    .pipe_enq__RDY (pipe_enq__RDY),
    .err_count     (err_count),
    .msg_count     (msg_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] exp_msg(input logic [31:0] meth, input logic [31:0] v);
    return {v, meth, 16'h0000, 16'h0001};
  endfunction

  // Scoreboard consumer and hold-stability monitor.
  always @(negedge CLK) begin
    if (prev_stall && pipe_enq__ENA) begin
      chk("hold_stable", pipe_enq_v, prev_data);
    end
    if (pipe_enq__ENA && pipe_enq__RDY) begin
      xfer_cyc.push_back(cycle);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_msg observed=%0h expected=none", pipe_enq_v);
      end
      if (sb.size() > 0) begin
        chk("msg_data", pipe_enq_v, sb.pop_front());
      end
    end
    prev_stall <= nRST && pipe_enq__ENA && !pipe_enq__RDY;
    prev_data  <= pipe_enq_v;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_beat(input logic [31:0] w);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    beat__ENA = 1'b1;
    beat_v    = w;
    while (!ok && n < 200) begin
      @(negedge CLK);
      ok = beat__RDY;
      if (!ok) stall_waits++;
      @(posedge CLK);
      #1;
      n++;
    end
    beat__ENA = 1'b0;
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL beat_timeout observed=stuck expected=accepted word=%0h", w);
    end
  endtask

  task automatic send_say(input logic [31:0] meth, input logic [31:0] v);
    sb.push_back(exp_msg(meth, v));
    send_beat(32'h0002_0001);
    send_beat(meth);
    send_beat(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST          = 1'b0;
    beat__ENA     = 1'b0;
    beat_v        = 32'h0;
    pipe_enq__RDY = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_beat_rdy", 96'(beat__RDY), 96'd0);
    chk("rst_enq_ena", 96'(pipe_enq__ENA), 96'd0);
    chk("rst_enq_v", pipe_enq_v, 96'd0);
    chk("rst_err", 96'(err_count), 96'd0);
    chk("rst_msg", 96'(msg_count), 96'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    idle(1);
    chk("post_rst_beat_rdy", 96'(beat__RDY), 96'd1);

    // 1: single say frame, one-cycle latency
    sb.push_back({32'hAA, 32'h5, 32'h1});
    send_beat(32'h0002_0001);
    send_beat(32'h0000_0005);
    chk("pre_v_ena", 96'(pipe_enq__ENA), 96'd0);
    send_beat(32'h0000_00AA);
    chk("lat_ena", 96'(pipe_enq__ENA), 96'd1);
    chk("lat_data", pipe_enq_v, {32'hAA, 32'h5, 32'h1});
    idle(2);
    chk("t1_msg", 96'(msg_count), 96'd1);

    // 2: four back-to-back frames
    xfer_cyc.delete();
    stall_waits = 0;
    for (int i = 0; i < 4; i++) begin
      send_say(32'h10 + 32'(i), 32'hB000 + 32'(i));
    end
    idle(3);
    chk("t2_no_stall", 96'(stall_waits), 96'd0);
    chk("t2_xfers", 96'(xfer_cyc.size()), 96'd4);
    for (int i = 1; i < 4 && i < xfer_cyc.size(); i++) begin
      chk("t2_gap", 96'(xfer_cyc[i] - xfer_cyc[i-1]), 96'd3);
    end
    chk("t2_msg", 96'(msg_count), 96'd5);

    // 3: downstream stalled across two frames
    pipe_enq__RDY = 1'b0;
    send_say(32'hA1, 32'hA2);
    fork
      send_say(32'hB1, 32'hB2);
      begin
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("t3_v_stalled", 96'(beat__RDY), 96'd0);
        chk("t3_ena_held", 96'(pipe_enq__ENA), 96'd1);
        chk("t3_data_held", pipe_enq_v, exp_msg(32'hA1, 32'hA2));
        repeat (4) @(posedge CLK);
        #1 pipe_enq__RDY = 1'b1;
      end
    join
    idle(4);
    chk("t3_msg", 96'(msg_count), 96'd7);
    chk("t3_sb_empty", 96'(sb.size()), 96'd0);

    // 4: unknown tag discarded, say with len 0 rejected, then a good frame
    send_beat(32'h0003_0007);
    send_beat(32'hDEAD_0000);
    send_beat(32'h0000_0001);
    send_beat(32'h0000_0002);
    chk("t4_err_discard", 96'(err_count), 96'd1);
    send_beat(32'h0000_0001);
    chk("t4_err_say_len0", 96'(err_count), 96'd2);
    send_say(32'h77, 32'h88);
    idle(3);
    chk("t4_err", 96'(err_count), 96'd2);
    chk("t4_msg", 96'(msg_count), 96'd8);
    chk("t4_sb_empty", 96'(sb.size()), 96'd0);

    // 5: bad length, then saturate the error counter
    send_beat(32'h0001_0001);
    send_beat(32'h0000_0000);
    chk("t5_err_badlen", 96'(err_count), 96'd3);
    send_say(32'h99, 32'h9A);
    idle(3);
    chk("t5_msg", 96'(msg_count), 96'd9);
    for (int i = 0; i < 251; i++) send_beat(32'h0000_0002);
    chk("t5_err_254", 96'(err_count), 96'd254);
    send_beat(32'h0000_0002);
    chk("t5_err_255", 96'(err_count), 96'd255);
    for (int i = 0; i < 4; i++) send_beat(32'h0000_0002);
    chk("t5_err_sat", 96'(err_count), 96'd255);

    // 6: reset mid-frame with a message held in the slot
    pipe_enq__RDY = 1'b0;
    send_say(32'hC1, 32'hC2);
    send_beat(32'h0002_0001);
    send_beat(32'h0000_0033);
    chk("t6_pre_ena", 96'(pipe_enq__ENA), 96'd1);
    nRST = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_ena", 96'(pipe_enq__ENA), 96'd0);
    chk("t6_rst_v", pipe_enq_v, 96'd0);
    chk("t6_rst_err", 96'(err_count), 96'd0);
    chk("t6_rst_msg", 96'(msg_count), 96'd0);
    chk("t6_rst_rdy", 96'(beat__RDY), 96'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    pipe_enq__RDY = 1'b1;
    idle(1);
    send_say(32'h1234, 32'h5678);
    idle(3);
    chk("t6_msg", 96'(msg_count), 96'd1);
    chk("t6_err", 96'(err_count), 96'd0);
    chk("t6_sb_empty", 96'(sb.size()), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
